// File: rtl/stream_pkg.sv
// Shared helpers for the host-link stream blocks (serializers and deserializers).
package stream_pkg;

  // Ceiling log2, minimum 1 so that a counter for a 1-entry range still has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Bit offset of beat k inside a word of `ratio` beats of `width` bits each.
  // lsb_first=1: first beat in the least-significant slot; 0: most-significant.
  function automatic int slot_offset(input int k, input int ratio, input int width,
                                     input int lsb_first);
    if (lsb_first != 0) return k * width;
    else return (ratio - 1 - k) * width;
  endfunction

endpackage

// File: rtl/stream_deser.sv
// stream_deser: collects RATIO narrow beats into one wide word on a
// valid/ready stream, one input beat per clock with no bubbles.
// Optional early word termination (i_last/o_last/o_nbeats) is enabled by
// defining STREAM_DESER_LAST_EN; the default build has fixed-length words.
module stream_deser
  import stream_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [IN_WIDTH-1:0]                i_data,
  input  logic                               i_valid,
  output logic                               o_ready,
  output logic [IN_WIDTH*RATIO-1:0]          o_data,
  output logic                               o_valid,
`ifdef STREAM_DESER_LAST_EN
  input  logic                               i_last,
  output logic                               o_last,
  output logic [stream_pkg::clog2(RATIO+1)-1:0] o_nbeats,
`endif
  input  logic                               i_ready
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = clog2(RATIO);
  localparam int NB_W      = clog2(RATIO + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]     cnt;
  logic [OUT_WIDTH-1:0] asm_q;
  logic [OUT_WIDTH-1:0] word_next;
  logic                 ends_word;
  logic                 in_xfer;
  logic                 out_xfer;

  // The beat being accepted closes the word: last slot, or an early end.
`ifdef STREAM_DESER_LAST_EN
  assign ends_word = (cnt == CNT_MAX) || i_last;
`else
  assign ends_word = (cnt == CNT_MAX);
`endif

  // Partial beats always go in; a closing beat needs the output slot free
  // or draining this cycle, which is the only i_ready -> o_ready path.
  assign o_ready  = !i_rst && (!ends_word || !o_valid || i_ready);
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;

  // Merge the incoming beat into its slot of the partially assembled word.
  always_comb begin
    word_next = asm_q;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CNT_W'(k))
        word_next[slot_offset(k, RATIO, IN_WIDTH, LSB_FIRST) +: IN_WIDTH] = i_data;
    end
  end

  // Assembly register and beat counter; cleared after each completed word
  // so unfilled slots of an early-ended word read as zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (in_xfer) begin
      if (ends_word) begin
        cnt   <= '0;
        asm_q <= '0;
      end else begin
        cnt   <= cnt + CNT_W'(1);
        asm_q <= word_next;
      end
    end
  end

  // Output register: a load wins over a drain so back-to-back words keep
  // o_valid high; otherwise a drain empties it and a stall holds it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (in_xfer && ends_word) begin
      o_valid <= 1'b1;
      o_data  <= word_next;
    end else if (out_xfer) begin
      o_valid <= 1'b0;
    end
  end

`ifdef STREAM_DESER_LAST_EN
  // Side-band for the word: early-end flag and how many beats were filled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_last   <= 1'b0;
      o_nbeats <= '0;
    end else if (in_xfer && ends_word) begin
      o_last   <= i_last;
      o_nbeats <= NB_W'(cnt) + NB_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stream_deser.sv
// Directed self-checking bench for stream_deser (RATIO=4, IN_WIDTH=8).
// Runs an LSB-first and an MSB-first instance side by side on shared inputs.
module tb_stream_deser;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;
  logic        rdy1, rdy2;
  logic [31:0] data1, data2;
  logic        val1, val2;
`ifdef STREAM_DESER_LAST_EN
  logic        in_last;
  logic        last1, last2;
  logic [2:0]  nb1, nb2;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  stream_deser #(.IN_WIDTH(8), .RATIO(4), .LSB_FIRST(1)) dut_lsb (
    .i_clk(clk), .i_rst(rst), .i_data(in_data), .i_valid(in_valid),
    .o_ready(rdy1), .o_data(data1), .o_valid(val1),
`ifdef STREAM_DESER_LAST_EN
    .i_last(in_last), .o_last(last1), .o_nbeats(nb1),
`endif
    .i_ready(out_ready)
  );

  stream_deser #(.IN_WIDTH(8), .RATIO(4), .LSB_FIRST(0)) dut_msb (
    .i_clk(clk), .i_rst(rst), .i_data(in_data), .i_valid(in_valid),
    .o_ready(rdy2), .o_data(data2), .o_valid(val2),
`ifdef STREAM_DESER_LAST_EN
    .i_last(in_last), .o_last(last2), .o_nbeats(nb2),
`endif
    .i_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
`ifdef STREAM_DESER_LAST_EN
    in_last = 1'b0;
`endif
    repeat (2) @(negedge clk);
    tests_run++;
    if (rdy1 !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b exp 0", rdy1); end
    tests_run++;
    if (val1 !== 1'b0 || data1 !== 32'h0) begin
      tests_failed++; $display("FAIL reset_out got valid=%b data=%h exp valid=0 data=00000000", val1, data1);
    end
`ifdef STREAM_DESER_LAST_EN
    tests_run++;
    if (last1 !== 1'b0 || nb1 !== 3'd0) begin
      tests_failed++; $display("FAIL reset_side got last=%b nb=%0d exp 0/0", last1, nb1);
    end
`endif
    rst = 1'b0;
    #1;
    tests_run++;
    if (rdy1 !== 1'b1) begin tests_failed++; $display("FAIL release_ready got %b exp 1", rdy1); end
  endtask

  task automatic test_basic();
    logic [7:0] beats [4];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_data = beats[i]; in_valid = 1'b1;
      tests_run++;
      if (val1 !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid beat %0d got %b exp 0", i, val1); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (val1 !== 1'b1 || data1 !== 32'h44332211) begin
      tests_failed++; $display("FAIL basic_lsb got valid=%b data=%h exp 1/44332211", val1, data1);
    end
    tests_run++;
    if (val2 !== 1'b1 || data2 !== 32'h11223344) begin
      tests_failed++; $display("FAIL basic_msb got valid=%b data=%h exp 1/11223344", val2, data2);
    end
    @(negedge clk);
    tests_run++;
    if (val1 !== 1'b0) begin tests_failed++; $display("FAIL basic_single_cycle got %b exp 0", val1); end
  endtask

  task automatic test_stall();
    logic [7:0] b;
    int acc;
    acc = 0;
    out_ready = 1'b0;
    b = 8'h01;
    // Beats 1..7 all go in even though the output is not drained.
    while (acc < 7) begin
      @(negedge clk);
      in_data = b; in_valid = 1'b1;
      #1;
      tests_run++;
      if (rdy1 !== 1'b1) begin tests_failed++; $display("FAIL stall_accept beat %0d got %b exp 1", acc + 1, rdy1); end
      if (acc >= 5) begin
        tests_run++;
        if (val1 !== 1'b1 || data1 !== 32'h04030201) begin
          tests_failed++; $display("FAIL stall_hold got valid=%b data=%h exp 1/04030201", val1, data1);
        end
      end
      acc++;
      b = b + 8'h01;
    end
    // Beat 8 must wait while the first word is still held.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_data = 8'h08; in_valid = 1'b1;
      #1;
      tests_run++;
      if (rdy1 !== 1'b0) begin tests_failed++; $display("FAIL stall_block got %b exp 0", rdy1); end
      tests_run++;
      if (data1 !== 32'h04030201) begin tests_failed++; $display("FAIL stall_stable got %h exp 04030201", data1); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (rdy1 !== 1'b1) begin tests_failed++; $display("FAIL stall_release_ready got %b exp 1", rdy1); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (val1 !== 1'b1 || data1 !== 32'h08070605) begin
      tests_failed++; $display("FAIL stall_second got valid=%b data=%h exp 1/08070605", val1, data1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (val1 !== 1'b0) begin tests_failed++; $display("FAIL stall_drain got %b exp 0", val1); end
  endtask

  task automatic test_back_to_back();
    int words;
    logic [31:0] expw;
    words = 0;
    out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16) begin in_data = 8'h10 + 8'(i); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (i < 16) begin
        tests_run++;
        if (rdy1 !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready beat %0d got %b exp 1", i, rdy1); end
      end
      if (val1 === 1'b1) begin
        for (int k = 0; k < 4; k++) expw[k*8 +: 8] = 8'h10 + 8'(4 * words + k);
        tests_run++;
        if (data1 !== expw) begin tests_failed++; $display("FAIL b2b_word %0d got %h exp %h", words, data1, expw); end
        words++;
      end
    end
    @(negedge clk);
    tests_run++;
    if (words != 4) begin tests_failed++; $display("FAIL b2b_count got %0d exp 4", words); end
  endtask

  task automatic test_reset_mid();
    int words;
    words = 0;
    out_ready = 1'b1;
    @(negedge clk); in_data = 8'hAA; in_valid = 1'b1;
    @(negedge clk); in_data = 8'hBB;
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 4) begin in_data = 8'h01 + 8'(i); in_valid = 1'b1; end
      else in_valid = 1'b0;
      if (val1 === 1'b1) begin
        tests_run++;
        if (data1 !== 32'h04030201) begin tests_failed++; $display("FAIL rst_mid_word got %h exp 04030201", data1); end
        words++;
      end
    end
    tests_run++;
    if (words != 1) begin tests_failed++; $display("FAIL rst_mid_count got %0d exp 1", words); end
  endtask

`ifdef STREAM_DESER_LAST_EN
  task automatic test_last();
    out_ready = 1'b1;
    @(negedge clk); in_data = 8'hAA; in_valid = 1'b1; in_last = 1'b0;
    @(negedge clk); in_data = 8'hBB; in_last = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    tests_run++;
    if (val1 !== 1'b1 || data1 !== 32'h0000BBAA || last1 !== 1'b1 || nb1 !== 3'd2) begin
      tests_failed++;
      $display("FAIL last_short got v=%b d=%h l=%b n=%0d exp 1/0000bbaa/1/2", val1, data1, last1, nb1);
    end
    tests_run++;
    if (data2 !== 32'hAABB0000) begin tests_failed++; $display("FAIL last_short_msb got %h exp aabb0000", data2); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_data = 8'h01 + 8'(i); in_valid = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0;
    tests_run++;
    if (val1 !== 1'b1 || data1 !== 32'h04030201 || last1 !== 1'b0 || nb1 !== 3'd4) begin
      tests_failed++;
      $display("FAIL last_full got v=%b d=%h l=%b n=%0d exp 1/04030201/0/4", val1, data1, last1, nb1);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef STREAM_DESER_LAST_EN
    test_last();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stream_deser.md
# stream_deser

Stream deserializer: collects RATIO consecutive narrow beats from a valid/ready stream and presents them as one wide word on a valid/ready stream. It is the receive-side counterpart of the byte serializers on the host link. It sits between the FT byte stream and wide command/sample consumers, typically followed by `stream_buf` when downstream timing needs a register slice. It sustains one input beat per clock with no bubbles.

## Interface
- `IN_WIDTH`, default 8: width of one input beat.
- `RATIO`, default 4: beats per output word; must be ≥ 2.
- `LSB_FIRST`, default 1: 1 places the first beat in the least-significant slot; 0 places it in the most-significant slot.
- Derived, not overridable: `OUT_WIDTH = IN_WIDTH*RATIO`; `CNT_W = $clog2(RATIO)`; `NB_W = $clog2(RATIO+1)`.

Ports:
- `i_clk` input 1: clock; all state is updated on its rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_data` input IN_WIDTH: upstream beat.
- `i_valid` input 1: upstream valid.
- `o_ready` output 1: upstream ready.
- `o_data` output OUT_WIDTH: assembled word.
- `o_valid` output 1: word valid.
- `i_ready` input 1: downstream ready.
- `i_last` input 1: ends the word early. Present only with `STREAM_DESER_LAST_EN`.
- `o_last` output 1: the word was ended early by `i_last`. Present only with `STREAM_DESER_LAST_EN`.
- `o_nbeats` output NB_W: number of filled beats in the word, range 1..RATIO. Present only with `STREAM_DESER_LAST_EN`.

## Operation
- **State**
  - Assembly register holds up to RATIO-1 beats.
  - Beat counter `cnt` runs 0..RATIO-1.
  - Output register holds `o_data`, `o_valid`, and the optional `o_last`/`o_nbeats`.
- **Transfers**
  - Input transfer: `i_valid && o_ready`.
  - Output transfer: `o_valid && i_ready`.
- **Input transfer with `cnt < RATIO-1`**
  - Beat is written into slot `cnt`. With LSB_FIRST=1, slot k is bits [k*IN_WIDTH +: IN_WIDTH]. With LSB_FIRST=0, slot k is slot RATIO-1-k.
  - `cnt` increments.
- **Input transfer with `cnt == RATIO-1`**
  - Completed word (assembly register plus current beat) is loaded into the output register.
  - `o_valid` is set to 1.
  - `cnt` wraps to 0.
  - Assembly register is cleared to 0.
- **o_ready**
  - `o_ready = !i_rst && (cnt != RATIO-1 || !o_valid || i_ready)`.
  - Partial beats are always accepted. The completing beat is accepted only if the output register is empty or is draining in the same cycle.
- **Output register**
  - Cleared to `o_valid=0` on an output transfer with no simultaneous load.
  - A simultaneous output transfer and load keeps `o_valid=1` and loads the new word.
- **Stall**: while `o_valid && !i_ready`, `o_data`, `o_last` and `o_nbeats` are held stable.
- **Reset mid-operation**: the partial word and any held output word are discarded without emission.

## Timing
- **Reset values**: `o_valid=0`, `o_data=0`, `o_last=0`, `o_nbeats=0`, `cnt=0`, assembly register 0. `o_ready=0` while `i_rst` is high and 1 in the first cycle after release.
- **Latency**: a completing beat accepted at edge N gives `o_valid=1` in the cycle after edge N.
- **Throughput**: with `i_ready` held high, one input beat per cycle is accepted and one word is emitted every RATIO cycles. `o_ready` never drops.
- **Combinational path**: the only path is `i_ready` → `o_ready`, and it is active only when `cnt == RATIO-1 && o_valid`. There are no combinational paths from `i_valid` or `i_data` to any output.

## Configuration
- Macro: `STREAM_DESER_LAST_EN`.
- **Defined**
  - `i_last`, `o_last` and `o_nbeats` ports exist.
  - A beat accepted with `i_last=1` completes the word immediately at any `cnt`. Unfilled slots are 0, `o_last=1`, `o_nbeats=cnt+1`, and `cnt` returns to 0.
  - `o_ready` uses the completing-beat condition whenever `cnt == RATIO-1 || i_last`.
  - Words completed normally (RATIO beats, no `i_last`) give `o_last=0` and `o_nbeats=RATIO`. A full-length word whose final beat carries `i_last` gives `o_last=1` and `o_nbeats=RATIO`.
- **Not defined**
  - The three ports are absent.
  - Every word is exactly RATIO beats.

## Structure
- Shared package `stream_pkg` holds:
  - the ceiling-log2 helper used for `CNT_W`/`NB_W`;
  - the slot-index function mapping beat k to its bit offset for both LSB_FIRST settings, shared with the serializer.
- No sub-module. When `o_ready` timing or the output path needs isolation, the integrating level instantiates `stream_buf` on the output.

## Test plan
- Defaults, `i_ready=1`, beats 0x11,0x22,0x33,0x44 on consecutive cycles → single-cycle `o_valid` one cycle after the 4th beat, `o_data=0x44332211`.
- `LSB_FIRST=0`, same beats → `o_data=0x11223344`.
- `i_ready=0`, 8 beats 0x01..0x08 offered continuously:
  - first word `0x04030201` is held stable;
  - beats 5–7 are accepted, then `o_ready=0` on beat 8;
  - raising `i_ready` for one cycle accepts 0x08 in the same cycle, and `o_data` becomes `0x08070605`.
- 16 continuous beats with `i_ready=1` → 4 words, `o_ready` constant 1.
- 2 beats 0xAA,0xBB, then `i_rst` pulse, then 0x01..0x04 → only `0x04030201` is emitted.
- `STREAM_DESER_LAST_EN`: 0xAA, then 0xBB with `i_last=1` → `o_data=0x0000BBAA`, `o_last=1`, `o_nbeats=2`. The next 4 plain beats give `o_last=0`, `o_nbeats=4`.
